// File: rtl/logic16_arbiter.sv
// ---------------------------------------------------------------------------
// logic16_arbiter
//
// Purpose: lets N_REQ requesters share one 16-bit bitwise logic unit. The unit
// is built only from the _and16 / _not16 gate arrays. A round-robin arbiter
// picks one pending request and latches its opcode and operands. The shared
// gates evaluate them, and the registered result is held until the consumer
// acknowledges it.
//
// Opcodes ({op[2i], op[2i+1]}): 00 AND, 01 NOT a, 10 NAND, 11 PASS a.
//
// Ports (all outputs registered):
//   in_clk     clock, rising edge
//   in_rst     asynchronous active-high reset
//   in_req     [0:N_REQ-1]    request, bit i = requester i
//   in_op      [0:2*N_REQ-1]  opcode of requester i at [2i:2i+1]
//   in_a/in_b  [0:16*N_REQ-1] operands of requester i at [16i:16i+15]
//   in_ack     consumer accepts out_y (only looked at in DONE)
//   out_gnt    [0:N_REQ-1]    one-cycle one-hot grant pulse
//   out_y      [0:15]         result
//   out_id     [0:1]          requester owning out_y
//   out_valid  out_y / out_id valid
//
// Build option: define LOGIC16_ARB_FIXED_PRIO_EN to use fixed priority, where
// the lowest asserted index always wins. The default build is round robin.
// ---------------------------------------------------------------------------

module _and16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  assign y = a & b;
endmodule

module _not16 (
  input  logic [15:0] a,
  output logic [15:0] y
);
  assign y = ~a;
endmodule

module logic16_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 16
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic [0:N_REQ-1]     in_req,
  input  logic [0:2*N_REQ-1]   in_op,
  input  logic [0:W*N_REQ-1]   in_a,
  input  logic [0:W*N_REQ-1]   in_b,
  input  logic                 in_ack,
  output logic [0:N_REQ-1]     out_gnt,
  output logic [0:W-1]         out_y,
  output logic [0:1]           out_id,
  output logic                 out_valid
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [1:0]     op_r;

  // ---------------- shared gate datapath on the latched operands ----------
  logic [15:0] and_ab, nand_ab, not_a, pass_a, y_sel;

  _and16 u_and_ab  (.a(a_r),    .b(b_r),      .y(and_ab));
  _not16 u_nand_ab (.a(and_ab),               .y(nand_ab));
  _not16 u_not_a   (.a(a_r),                  .y(not_a));
  _and16 u_pass_a  (.a(a_r),    .b(16'hFFFF), .y(pass_a));

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    y_sel = pass_a;
    case (op_r)
      2'b00:   y_sel = and_ab;
      2'b01:   y_sel = not_a;
      2'b10:   y_sel = nand_ab;
      default: y_sel = pass_a;
    endcase
  end

  // ---------------- winner selection ---------------------------------------
  // The search runs backwards over the priority order. The last hit is the
  // highest-priority requester, so no early exit is needed.
  logic       found;
  logic [1:0] win;

`ifdef LOGIC16_ARB_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (in_req[i]) begin
        found = 1'b1;
        win   = 2'(i);
      end
    end
  end
`else
  logic [1:0] ptr;
  logic [1:0] cand;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = 2'((int'(ptr) + k) % N_REQ);
      if (in_req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end
`endif

  // ---------------- control FSM with registered outputs ---------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state     <= IDLE;
      out_gnt   <= '0;
      out_y     <= '0;
      out_id    <= '0;
      out_valid <= 1'b0;
      // NOTE: the operand registers are plain flops, not a memory. Resetting
      // them keeps the datapath free of X before the first grant.
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= '0;
`ifndef LOGIC16_ARB_FIXED_PRIO_EN
      ptr       <= 2'(N_REQ - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          out_gnt <= '0;
          if (found) begin
            state        <= EXEC;
            out_gnt[win] <= 1'b1;
            out_id       <= win;
            op_r         <= in_op[2*int'(win) +: 2];
            a_r          <= in_a[W*int'(win) +: W];
            b_r          <= in_b[W*int'(win) +: W];
          end
        end
        EXEC: begin
          state     <= DONE;
          out_y     <= y_sel;
          out_valid <= 1'b1;
          out_gnt   <= '0;
        end
        DONE: begin
          if (in_ack) begin
            state     <= IDLE;
            out_valid <= 1'b0;
`ifndef LOGIC16_ARB_FIXED_PRIO_EN
            ptr       <= out_id;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/logic16_arbiter.md
# logic16_arbiter

Shares one 16-bit bitwise logic datapath, built from the `_and16` and `_not16` gate arrays, among N_REQ requesters. A round-robin arbiter selects one pending request, latches its operands and opcode, and drives them through the shared gates. It registers the 16-bit result and holds it until the consumer acknowledges. It sits between requesting blocks (sequencer, test harness) and the gate-level datapath, so no requester instantiates its own logic unit.

## Interface
- N_REQ, 4, number of requesters; legal range 2–4.
- W, 16, operand width; fixed at 16 to match the gate arrays.
- in_clk  input  1  clock; all state updates on rising edge.
- in_rst  input  1  reset, asynchronous, active-high.
- in_req  input  [0:N_REQ-1]  per-requester request; bit i = requester i.
- in_op  input  [0:2*N_REQ-1]  opcode of requester i at bits [2i:2i+1].
- in_a  input  [0:16*N_REQ-1]  operand A of requester i at bits [16i:16i+15].
- in_b  input  [0:16*N_REQ-1]  operand B, same packing.
- in_ack  input  1  consumer accepts the current result.
- out_gnt  output  [0:N_REQ-1]  one-hot grant pulse.
- out_y  output  [0:15]  result.
- out_id  output  [0:1]  index of the requester that owns out_y.
- out_valid  output  1  out_y/out_id valid.

## Operation
- Opcodes (bits [2i:2i+1] read as the 2-bit value {op[2i], op[2i+1]}):
  - 00: AND, y = a & b.
  - 01: NOT, y = ~a.
  - 10: NAND, y = ~(a & b).
  - 11: PASS, y = a & 16'hFFFF.
  - All four are realised only through `_and16`/`_not16` instances plus a select.
- States:
  - IDLE → EXEC: any in_req bit high. The winner's op/a/b are latched into internal registers, its index into out_id, and out_gnt[winner] is set.
  - IDLE → IDLE: no request.
  - EXEC → DONE: unconditional. out_y takes the gate result of the latched operands, out_valid is set, out_gnt is cleared.
  - DONE → IDLE: in_ack high. out_valid is cleared and the priority pointer becomes out_id.
  - DONE → DONE: in_ack low. out_y, out_id and out_valid hold.
- Round robin: search order is ptr+1, ptr+2, … modulo N_REQ. ptr resets to N_REQ-1, so requester 0 has top priority after reset. Only IDLE evaluates in_req.
- Requester contract:
  - a, b and op must be valid in the cycle req is high.
  - Operands are captured at the grant edge and may change afterwards.
  - A requester still asserting req in the cycle after its out_gnt pulse is treated as a new request.
- in_ack is ignored in IDLE and EXEC.
- in_req bits for indices ≥ N_REQ do not exist; out_id never exceeds N_REQ-1.

## Timing
- Reset values: out_gnt=0, out_y=16'h0000, out_id=0, out_valid=0, state=IDLE, ptr=N_REQ-1, latched operands=0.
- Asserting in_rst in any state aborts the in-flight operation immediately. No ack is required, and no result is delivered afterwards.
- Request sampled at edge k:
  - out_gnt high for exactly the cycle after edge k.
  - out_valid high from edge k+1.
- in_ack sampled high at edge m while in DONE: out_valid low after m. The earliest next grant is at edge m+1.
- Minimum spacing is 3 cycles per operation. A request and an ack in the same cycle do not overlap; the request waits for IDLE.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- LOGIC16_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. The lowest asserted index always wins, and ptr is neither updated nor used.
  - Undefined (default): round robin as specified above.

## Test plan
- Reset: assert in_rst mid-DONE with out_valid=1 → all outputs 0 and state IDLE immediately. After release, a req0 AND of 16'hF0F0 & 16'hFF00 → out_y=16'hF000, out_id=0.
- Opcodes: requester 1 with a=16'h1234, b=16'h00FF, op 00/01/10/11 → out_y = 16'h0034 / 16'hEDCB / 16'hFFCB / 16'h1234.
- Round robin: all four requesting continuously, ack each result one cycle after valid → out_id sequence 0,1,2,3,0,1. Each out_gnt pulse lasts 1 cycle, and grants are spaced 3 cycles apart.
- Backpressure: in_ack held low 10 cycles after valid → out_y/out_id stable, no new out_gnt, and a pending req2 waits. Ack → out_valid drops next edge and out_gnt[2] rises at the following edge.
- Operand capture: change a from 16'hAAAA to 16'h5555 the cycle after grant with op NOT → out_y=16'h5555.
- With LOGIC16_ARB_FIXED_PRIO_EN: req0 and req3 both held high → out_id 0 every time and requester 3 is never granted.
